// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write port, two read ports and the
// soft-clear handshake.
//
// Signals
//   we, waddr, wdata      write port (driven by writeback)
//   raddr1, raddr2        read addresses (driven by decode)
//   rdata1, rdata2        combinational read data (driven by the register file)
//   clear_req             request a soft clear of the whole array
//   busy, clear_done      soft-clear status (registered)
//   wr_drop               one-cycle pulse after a write was rejected
//
// Modports
//   master  the datapath side that issues accesses
//   slave   the register file itself

interface param_register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              clear_req;
    logic              busy;
    logic              clear_done;
    logic              wr_drop;

    modport master (
        output we,
        output waddr,
        output wdata,
        output raddr1,
        output raddr2,
        output clear_req,
        input  rdata1,
        input  rdata2,
        input  busy,
        input  clear_done,
        input  wr_drop
    );

    modport slave (
        input  we,
        input  waddr,
        input  wdata,
        input  raddr1,
        input  raddr2,
        input  clear_req,
        output rdata1,
        output rdata2,
        output busy,
        output clear_done,
        output wr_drop
    );

endinterface

// File: rtl/param_register_file.sv
// Parametrised register file: 2**ADDR_W entries of DATA_W bits, two
// combinational read ports, one synchronous write port, optional write
// bypass, optional hardwired-zero register 0 and a one-entry-per-cycle
// soft-clear sweep.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (clears array and sequencer)
//   bus   param_register_file_if.slave bundle (read/write/clear signals)
//
// Parameters
//   DATA_W    bits per register
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   ZERO_REG  1 = register 0 reads 0 and ignores writes
//   BYPASS    1 = an accepted same-cycle write is forwarded to a matching read

module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic                 clk,
    input logic                 rst,
    param_register_file_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic busy;
    logic clear_done;
    logic wr_drop;

    logic zero_hit_w;
    logic write_ok;

    // Writes to the hardwired register 0 are swallowed without a drop pulse.
    assign zero_hit_w = (ZERO_REG != 0) && (bus.waddr == '0);
    assign write_ok   = bus.we && (state == IDLE) && !zero_hit_w;

    // Read port 1
    always_comb begin
        bus.rdata1 = mem[bus.raddr1];
        if ((ZERO_REG != 0) && (bus.raddr1 == '0)) begin
            bus.rdata1 = '0;
        end else if ((BYPASS != 0) && write_ok
                     && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
        end
    end

    // Read port 2
    always_comb begin
        bus.rdata2 = mem[bus.raddr2];
        if ((ZERO_REG != 0) && (bus.raddr2 == '0)) begin
            bus.rdata2 = '0;
        end else if ((BYPASS != 0) && write_ok
                     && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
        end
    end

    // Sequencer, array and registered status flags.
    // busy mirrors the CLEAR state one-for-one, so it is high for exactly
    // DEPTH cycles; clear_done is set on the edge that leaves CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A write in the request cycle still lands; the sweep
                    // zeroes it afterwards.
                    if (write_ok) begin
                        mem[bus.waddr] <= bus.wdata;
                    end
                    if (bus.clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    // Final increment wraps ptr back to 0.
                    ptr      <= ptr + 1'b1;
                    wr_drop  <= bus.we;
                    if (ptr == LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.clear_done = clear_done;
    assign bus.wr_drop    = wr_drop;

endmodule

// File: tb/tb_param_register_file.sv
// Testbench for param_register_file: three instances (bypass, no bypass,
// zero register) driven with the same stimulus and compared to a model.

`timescale 1ns / 100ps

module tb_param_register_file;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int ND = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic          clear_req = 1'b0;

    always #10 clk = ~clk;

    param_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    param_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    param_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();

    assign bus_a.we = we;
    assign bus_a.waddr = waddr;
    assign bus_a.wdata = wdata;
    assign bus_a.raddr1 = raddr1;
    assign bus_a.raddr2 = raddr2;
    assign bus_a.clear_req = clear_req;
    assign bus_b.we = we;
    assign bus_b.waddr = waddr;
    assign bus_b.wdata = wdata;
    assign bus_b.raddr1 = raddr1;
    assign bus_b.raddr2 = raddr2;
    assign bus_b.clear_req = clear_req;
    assign bus_z.we = we;
    assign bus_z.waddr = waddr;
    assign bus_z.wdata = wdata;
    assign bus_z.raddr1 = raddr1;
    assign bus_z.raddr2 = raddr2;
    assign bus_z.clear_req = clear_req;

    param_register_file #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    param_register_file #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    param_register_file #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)
    ) dut_z (.clk(clk), .rst(rst), .bus(bus_z));

    // Reference model: per-instance array contents plus sweep progress.
    int          zero_cfg [3] = '{0, 0, 1};
    int          byp_cfg  [3] = '{1, 0, 1};
    logic [DW-1:0] mmem [3][ND];
    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_drop = 0;
    int          m_sweep = 0;

    int n_assert = 0;
    int n_fail = 0;

    // Observations latched at the most recent check point.
    logic [DW-1:0] o_rd1_a, o_rd2_a, o_rd1_b, o_rd1_z;
    logic          o_busy, o_done, o_drop, o_drop_z;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit accepted(input int c);
        return we && !m_busy && !(zero_cfg[c] != 0 && waddr == 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int c,
                                             input logic [AW-1:0] a);
        if (zero_cfg[c] != 0 && a == 0) return '0;
        if (byp_cfg[c] != 0 && accepted(c) && waddr == a) return wdata;
        return mmem[c][a];
    endfunction

    task automatic model_edge();
        bit acc [3];
        for (int c = 0; c < 3; c++) acc[c] = accepted(c);
        if (rst) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < ND; i++) mmem[c][i] = '0;
            m_busy = 0;
            m_done = 0;
            m_drop = 0;
            m_sweep = 0;
            m_valid = 1;
        end else begin
            m_drop = we && m_busy;
            m_done = 0;
            if (m_busy) begin
                for (int c = 0; c < 3; c++) mmem[c][m_sweep] = '0;
                m_sweep++;
                if (m_sweep == ND) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                for (int c = 0; c < 3; c++)
                    if (acc[c]) mmem[c][waddr] = wdata;
                if (clear_req) begin
                    m_busy = 1;
                    m_sweep = 0;
                end
            end
        end
    endtask

    // One clock cycle: check at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        o_rd1_a = bus_a.rdata1;
        o_rd2_a = bus_a.rdata2;
        o_rd1_b = bus_b.rdata1;
        o_rd1_z = bus_z.rdata1;
        o_busy = bus_a.busy;
        o_done = bus_a.clear_done;
        o_drop = bus_a.wr_drop;
        o_drop_z = bus_z.wr_drop;
        if (m_valid) begin
            chk("a_rd1", bus_a.rdata1, exp_rd(0, raddr1));
            chk("a_rd2", bus_a.rdata2, exp_rd(0, raddr2));
            chk("b_rd1", bus_b.rdata1, exp_rd(1, raddr1));
            chk("b_rd2", bus_b.rdata2, exp_rd(1, raddr2));
            chk("z_rd1", bus_z.rdata1, exp_rd(2, raddr1));
            chk("z_rd2", bus_z.rdata2, exp_rd(2, raddr2));
            chk("a_busy", 16'(bus_a.busy), 16'(m_busy));
            chk("b_busy", 16'(bus_b.busy), 16'(m_busy));
            chk("z_busy", 16'(bus_z.busy), 16'(m_busy));
            chk("a_done", 16'(bus_a.clear_done), 16'(m_done));
            chk("b_done", 16'(bus_b.clear_done), 16'(m_done));
            chk("z_done", 16'(bus_z.clear_done), 16'(m_done));
            chk("a_drop", 16'(bus_a.wr_drop), 16'(m_drop));
            chk("b_drop", 16'(bus_b.wr_drop), 16'(m_drop));
            chk("z_drop", 16'(bus_z.wr_drop), 16'(m_drop));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Scan every entry through both ports between two edges (idle, no write).
    task automatic read_all(input bit want_zero);
        we = 1'b0;
        clear_req = 1'b0;
        for (int a = 0; a < ND; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(ND - 1 - a);
            #1;
            chk("scan_a1", bus_a.rdata1, exp_rd(0, raddr1));
            chk("scan_b2", bus_b.rdata2, exp_rd(1, raddr2));
            chk("scan_z1", bus_z.rdata1, exp_rd(2, raddr1));
            if (want_zero) begin
                chk("zero_a", bus_a.rdata1, 16'h0000);
                chk("zero_b", bus_b.rdata2, 16'h0000);
            end
        end
    endtask

    task automatic fill();
        for (int a = 0; a < ND; a++) begin
            we = 1'b1;
            waddr = AW'(a);
            wdata = DW'(a + 1);
            tick();
        end
        we = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        read_all(1);

        // Basic writes and reads
        we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5;
        tick();
        waddr = 3'd5; wdata = 16'h1234;
        tick();
        we = 1'b0; raddr1 = 3'd3; raddr2 = 3'd5;
        tick();
        chk("basic_r3", o_rd1_a, 16'hA5A5);
        chk("basic_r5", o_rd2_a, 16'h1234);

        // Bypass versus registered visibility
        we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; raddr1 = 3'd2;
        tick();
        chk("byp_on", o_rd1_a, 16'hBEEF);
        chk("byp_off_old", o_rd1_b, 16'h0000);
        we = 1'b0;
        tick();
        chk("byp_off_new", o_rd1_b, 16'hBEEF);

        // Hardwired zero register
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0;
        tick();
        chk("zreg_rd", o_rd1_z, 16'h0000);
        we = 1'b0;
        tick();
        chk("zreg_rd_after", o_rd1_z, 16'h0000);
        chk("zreg_nodrop", 16'(o_drop_z), 16'h0000);

        // Soft clear with a dropped write and an ignored re-request
        fill();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        raddr1 = 3'd7; raddr2 = 3'd6;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            we = (i == 2);
            waddr = 3'd6;
            wdata = 16'h1111;
            clear_req = (i == 4);
            tick();
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
            if (i < 8) chk("reg7_hold", o_rd1_a, 16'd8);
            if (i == 3) begin
                chk("drop_pulse", 16'(o_drop), 16'h0001);
                chk("reg6_kept", o_rd2_a, 16'd7);
            end
            if (i == 8) chk("done_at_fall", 16'(o_done), 16'h0001);
        end
        chk("busy_len", 16'(busy_cnt), 16'd8);
        chk("done_once", 16'(done_cnt), 16'd1);
        read_all(1);

        // Write in the request cycle is swept away
        we = 1'b1; waddr = 3'd4; wdata = 16'h7777; clear_req = 1'b1;
        tick();
        we = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        read_all(1);

        // Reset during the sweep
        fill();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy_seen", 16'(o_busy), 16'h0001);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_done) done_cnt++;
            if (i == 0) chk("rst_busy_low", 16'(o_busy), 16'h0000);
        end
        chk("rst_no_done", 16'(done_cnt), 16'h0000);
        read_all(1);
        we = 1'b1; waddr = 3'd5; wdata = 16'hCAFE;
        tick();
        we = 1'b0; raddr1 = 3'd5;
        tick();
        chk("rst_write_ok", o_rd1_b, 16'hCAFE);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            waddr = AW'($urandom);
            wdata = DW'($urandom);
            raddr1 = AW'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : AW'($urandom);
            clear_req = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        we = 1'b0;
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        read_all(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
